jtdsp16_pcu: RTL and testbench

Parametrised program control unit for the JTDSP16 core: the next generation of the ROM address arithmetic unit. It generates the ROM fetch address, keeps a multi-level return stack, runs zero-overhead hardware loops (`do K {…} N times`), defers interrupts across loops and ISRs, and maintains the table pointer with signed post-increment. It sits between the instruction decoder, which issues one-cycle command strobes, and the program ROM.

---
 rtl/jtdsp16_pcu_pkg.sv | 31 +++
 rtl/jtdsp16_pcu_if.sv | 39 +++
 rtl/jtdsp16_pcu_stack.sv | 46 ++++
 rtl/jtdsp16_pcu.sv | 105 ++++++++++
 tb/tb_jtdsp16_pcu.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/jtdsp16_pcu_pkg.sv
// Shared definitions for the JTDSP16 program control unit: default parameters
// and the next-pc source priority encoding.
package jtdsp16_pcu_pkg;

   localparam int unsigned DEF_AW          = 16;
   localparam int unsigned DEF_IW          = 12;
   localparam int unsigned DEF_STACK_DEPTH = 4;
   localparam int unsigned DEF_LCW         = 7;
   localparam int unsigned DEF_LLW         = 4;
   localparam int unsigned DEF_IRQ_VEC     = 1;
   localparam int unsigned DEF_RST_PC      = 0;

   // Listed in priority order, highest first
   typedef enum logic [2:0] {
      SRC_JUMP,
      SRC_RET,
      SRC_RETI,
      SRC_LOOP,
      SRC_SEQ
   } pc_src_e;

   function automatic pc_src_e pick_src(input logic jump, input logic ret,
                                        input logic reti, input logic wrap);
      if (jump) return SRC_JUMP;
      if (ret)  return SRC_RET;
      if (reti) return SRC_RETI;
      if (wrap) return SRC_LOOP;
      return SRC_SEQ;
   endfunction

endpackage

// File: rtl/jtdsp16_pcu_if.sv
// Decoder <-> program control unit bus: command strobes in, fetch state out.
interface jtdsp16_pcu_if #(
   parameter int unsigned AW  = 16,
   parameter int unsigned IW  = 12,
   parameter int unsigned LCW = 7,
   parameter int unsigned LLW = 4
);
   logic           cen;
   logic [AW-1:0]  din;
   logic           goto_en;
   logic           gosub;
   logic           ret;
   logic           reti;
   logic           do_en;
   logic [LLW-1:0] do_len;
   logic [LCW-1:0] do_cnt;
   logic           pt_ld;
   logic           posti;
   logic [IW-1:0]  i;
   logic           irq;
   logic [AW-1:0]  pc;
   logic [AW-1:0]  pt;
   logic           in_loop;
   logic           in_isr;
   logic           stk_ovf;
   logic           stk_unf;

   modport master (
      output cen, din, goto_en, gosub, ret, reti, do_en, do_len, do_cnt,
             pt_ld, posti, i, irq,
      input  pc, pt, in_loop, in_isr, stk_ovf, stk_unf
   );

   modport slave (
      input  cen, din, goto_en, gosub, ret, reti, do_en, do_len, do_cnt,
             pt_ld, posti, i, irq,
      output pc, pt, in_loop, in_isr, stk_ovf, stk_unf
   );
endinterface

// File: rtl/jtdsp16_pcu_stack.sv
// Return-address stack with sticky overflow/underflow flags. A push when full
// drops the entry; a pop when empty leaves the stack untouched.
module jtdsp16_pcu_stack #(
   parameter int unsigned AW          = 16,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);
   localparam int unsigned IXW = $clog2(STACK_DEPTH);
   localparam int unsigned SPW = IXW + 1;

   logic [SPW-1:0] sp;
   logic [AW-1:0]  mem [STACK_DEPTH];

   assign empty = (sp == '0);
   assign full  = (sp == SPW'(STACK_DEPTH));
   assign top   = mem[IXW'(sp - SPW'(1))];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (push) begin
         if (full) ovf <= 1'b1;
         else      sp  <= sp + SPW'(1);
      end else if (pop) begin
         if (empty) unf <= 1'b1;
         else       sp  <= sp - SPW'(1);
      end
   end

   // Storage needs no reset: entries are only read below the stack pointer
   always_ff @(posedge clk) begin
      if (push && !full) mem[IXW'(sp)] <= din;
   end
endmodule

// File: rtl/jtdsp16_pcu.sv
// JTDSP16 program control unit: fetch address sequencing, return stack,
// zero-overhead loops, deferred interrupts and the table pointer.
module jtdsp16_pcu
   import jtdsp16_pcu_pkg::*;
#(
   parameter int unsigned AW          = DEF_AW,
   parameter int unsigned IW          = DEF_IW,
   parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
   parameter int unsigned LCW         = DEF_LCW,
   parameter int unsigned LLW         = DEF_LLW,
   parameter logic [AW-1:0] IRQ_VEC   = AW'(DEF_IRQ_VEC),
   parameter logic [AW-1:0] RST_PC    = AW'(DEF_RST_PC)
) (
   input  logic           clk,
   input  logic           rst,
   jtdsp16_pcu_if.slave   bus
);
   logic [AW-1:0]  pc_r, pt_r, pi_r, lp_start, lp_end;
   logic [LCW-1:0] cnt;
   logic           in_loop_r, in_isr_r, irq_pend;
   logic [AW-1:0]  next_pc_c, seq_c, stk_top;
   logic           stk_empty, unused_full, stk_ovf, stk_unf;
   logic           jump_c, wrap_c, take_c, loop_start_c;
   pc_src_e        src_c;

   assign next_pc_c = pc_r + AW'(1);
   assign jump_c    = bus.goto_en | bus.gosub;
   assign wrap_c    = in_loop_r && (pc_r == lp_end);
   assign src_c     = pick_src(jump_c, bus.ret, bus.reti, wrap_c);
   assign take_c    = (irq_pend | bus.irq) & ~in_isr_r & ~in_loop_r;
   // A loop may only start from plain sequential flow outside an interrupt take
   assign loop_start_c = bus.do_en && !in_loop_r && (bus.do_len != '0) &&
                         (bus.do_cnt >= LCW'(2)) && (src_c == SRC_SEQ) && !take_c;

   always_comb begin
      seq_c = next_pc_c;
      case (src_c)
         SRC_JUMP: seq_c = bus.din;
         SRC_RET:  seq_c = stk_empty ? next_pc_c : stk_top;
         SRC_RETI: seq_c = pi_r;
         SRC_LOOP: seq_c = (cnt > LCW'(1)) ? lp_start : next_pc_c;
         default:  seq_c = next_pc_c;
      endcase
   end

   jtdsp16_pcu_stack #(.AW(AW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cen & bus.gosub),
      .pop   (bus.cen & (src_c == SRC_RET)),
      .din   (next_pc_c),
      .top   (stk_top),
      .empty (stk_empty),
      .full  (unused_full),
      .ovf   (stk_ovf),
      .unf   (stk_unf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r      <= RST_PC;
         pt_r      <= '0;
         pi_r      <= '0;
         lp_start  <= '0;
         lp_end    <= '0;
         cnt       <= '0;
         in_loop_r <= 1'b0;
         in_isr_r  <= 1'b0;
         irq_pend  <= 1'b0;
      end else if (bus.cen) begin
         pc_r <= take_c ? IRQ_VEC : seq_c;

         if (take_c) begin
            pi_r     <= seq_c;
            in_isr_r <= 1'b1;
            irq_pend <= 1'b0;
         end else begin
            irq_pend <= irq_pend | bus.irq;
            if (src_c == SRC_RETI) in_isr_r <= 1'b0;
         end

         if (loop_start_c) begin
            lp_start  <= next_pc_c;
            lp_end    <= pc_r + AW'(bus.do_len);
            cnt       <= bus.do_cnt;
            in_loop_r <= 1'b1;
         end else if (src_c == SRC_JUMP || src_c == SRC_RET) begin
            in_loop_r <= 1'b0;
         end else if (src_c == SRC_LOOP) begin
            if (cnt > LCW'(1)) cnt       <= cnt - LCW'(1);
            else               in_loop_r <= 1'b0;
         end

         if (bus.pt_ld)      pt_r <= bus.din;
         else if (bus.posti) pt_r <= pt_r + AW'($signed(bus.i));
      end
   end

   assign bus.pc      = pc_r;
   assign bus.pt      = pt_r;
   assign bus.in_loop = in_loop_r;
   assign bus.in_isr  = in_isr_r;
   assign bus.stk_ovf = stk_ovf;
   assign bus.stk_unf = stk_unf;
endmodule

// File: tb/tb_jtdsp16_pcu.sv
// Directed bench for jtdsp16_pcu: expected fetch addresses are queued as each
// command is driven and compared against pc after the clock edge.
module tb_jtdsp16_pcu;
   import jtdsp16_pcu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [15:0] exp_q[$];

   jtdsp16_pcu_if #(.AW(16), .IW(12), .LCW(7), .LLW(4)) bus ();

   jtdsp16_pcu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_cmds();
      bus.goto_en = 1'b0;
      bus.gosub   = 1'b0;
      bus.ret     = 1'b0;
      bus.reti    = 1'b0;
      bus.do_en   = 1'b0;
      bus.pt_ld   = 1'b0;
      bus.posti   = 1'b0;
      bus.irq     = 1'b0;
   endtask

   // Queue the expected next fetch, clock once, then compare and drop strobes
   task automatic step(input logic [15:0] exp_pc);
      logic [15:0] e;
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("pc", 32'(bus.pc), 32'(e));
      clear_cmds();
   endtask

   initial begin
      bus.cen    = 1'b0;
      bus.din    = '0;
      bus.do_len = '0;
      bus.do_cnt = '0;
      bus.i      = '0;
      clear_cmds();

      #17;
      chk("rst_pc", 32'(bus.pc), 32'h0);
      chk("rst_pt", 32'(bus.pt), 32'h0);
      chk("rst_flags", {28'h0, bus.in_loop, bus.in_isr, bus.stk_ovf, bus.stk_unf}, 32'h0);
      rst = 1'b0;
      bus.cen = 1'b1;

      for (int n = 1; n <= 5; n++) step(16'(n));
      chk("idle_flags", {28'h0, bus.in_loop, bus.in_isr, bus.stk_ovf, bus.stk_unf}, 32'h0);

      // cen low freezes everything
      bus.cen = 1'b0; bus.goto_en = 1'b1; bus.din = 16'h0077;
      step(16'h0005);
      bus.cen = 1'b1;

      // Loop of 3 x 3 with an irq arriving mid-loop
      bus.goto_en = 1'b1; bus.din = 16'h0010;
      step(16'h0010);
      bus.do_en = 1'b1; bus.do_len = 4'd3; bus.do_cnt = 7'd3;
      step(16'h0011);
      chk("loop_on", 32'(bus.in_loop), 32'h1);
      bus.irq = 1'b1;
      step(16'h0012);
      step(16'h0013);
      step(16'h0011);
      step(16'h0012);
      step(16'h0013);
      step(16'h0011);
      step(16'h0012);
      step(16'h0013);
      chk("loop_last", 32'(bus.in_loop), 32'h1);
      chk("isr_deferred", 32'(bus.in_isr), 32'h0);
      step(16'h0014);
      chk("loop_off", 32'(bus.in_loop), 32'h0);
      step(16'h0001);
      chk("isr_on", 32'(bus.in_isr), 32'h1);
      step(16'h0002);
      bus.reti = 1'b1;
      step(16'h0015);
      chk("isr_off", 32'(bus.in_isr), 32'h0);

      // Five nested calls into a 4-deep stack
      bus.gosub = 1'b1; bus.din = 16'h0100; step(16'h0100);
      bus.gosub = 1'b1; bus.din = 16'h0200; step(16'h0200);
      bus.gosub = 1'b1; bus.din = 16'h0300; step(16'h0300);
      bus.gosub = 1'b1; bus.din = 16'h0400; step(16'h0400);
      chk("no_ovf_yet", 32'(bus.stk_ovf), 32'h0);
      bus.gosub = 1'b1; bus.din = 16'h0500; step(16'h0500);
      chk("ovf", 32'(bus.stk_ovf), 32'h1);
      bus.ret = 1'b1; step(16'h0301);
      bus.ret = 1'b1; step(16'h0201);
      bus.ret = 1'b1; step(16'h0101);
      bus.ret = 1'b1; step(16'h0016);
      chk("no_unf_yet", 32'(bus.stk_unf), 32'h0);
      bus.ret = 1'b1; step(16'h0017);
      chk("unf", 32'(bus.stk_unf), 32'h1);

      // irq coincident with a call: the call target becomes the resume address
      bus.goto_en = 1'b1; bus.din = 16'h0040; step(16'h0040);
      bus.gosub = 1'b1; bus.din = 16'h0200; bus.irq = 1'b1;
      step(16'h0001);
      chk("isr_gosub", 32'(bus.in_isr), 32'h1);
      bus.reti = 1'b1; step(16'h0200);
      step(16'h0201);
      bus.ret = 1'b1; step(16'h0041);
      chk("sticky", {30'h0, bus.stk_ovf, bus.stk_unf}, 32'h3);

      // Table pointer
      bus.pt_ld = 1'b1; bus.din = 16'h0100; step(16'h0042);
      chk("pt_ld", 32'(bus.pt), 32'h0100);
      bus.i = 12'hFFE;
      bus.posti = 1'b1; step(16'h0043);
      chk("posti1", 32'(bus.pt), 32'h00FE);
      bus.posti = 1'b1; step(16'h0044);
      bus.posti = 1'b1; step(16'h0045);
      chk("posti3", 32'(bus.pt), 32'h00FA);
      bus.pt_ld = 1'b1; bus.posti = 1'b1; bus.din = 16'h1234; step(16'h0046);
      chk("pt_ld_prio", 32'(bus.pt), 32'h1234);
      bus.i = 12'h005; bus.posti = 1'b1; step(16'h0047);
      chk("posti_pos", 32'(bus.pt), 32'h1239);

      // Degenerate loop count runs the body once; a jump aborts a loop
      bus.do_en = 1'b1; bus.do_len = 4'd3; bus.do_cnt = 7'd1; step(16'h0048);
      chk("no_loop", 32'(bus.in_loop), 32'h0);
      bus.do_en = 1'b1; bus.do_len = 4'd2; bus.do_cnt = 7'd5; step(16'h0049);
      chk("loop2_on", 32'(bus.in_loop), 32'h1);
      bus.goto_en = 1'b1; bus.din = 16'h0080; step(16'h0080);
      chk("loop_abort", 32'(bus.in_loop), 32'h0);

      // Asynchronous reset takes effect without a clock edge
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_pc", 32'(bus.pc), 32'h0);
      chk("arst_pt", 32'(bus.pt), 32'h0);
      chk("arst_flags", {28'h0, bus.in_loop, bus.in_isr, bus.stk_ovf, bus.stk_unf}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step(16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
